// File: rtl/debug_unit_if.sv
// debug_unit_if: UART byte link between the debug unit (slave) and the host-side
// receiver/transmitter pair (master).
interface debug_unit_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    modport master (output rx_data, rx_valid, tx_busy, input tx_data, tx_start);
    modport slave  (input rx_data, rx_valid, tx_busy, output tx_data, tx_start);
endinterface

// File: rtl/debug_unit.sv
// debug_unit: host-side debug controller decoding UART commands and dumping pipeline state.
// Define DEBUG_CYCLE_COUNT_EN to count pc_enable cycles and append the count to each dump.
module debug_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int RESET_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    debug_unit_if.slave           uart,
    input  logic [DATA_WIDTH-1:0] pc_addr_in,
    input  logic [DATA_WIDTH-1:0] pc_instr_in,
    input  logic [DATA_WIDTH-1:0] reg_w_data_in,
    input  logic [DATA_WIDTH-1:0] reg_rt_data_in,
    input  logic [DATA_WIDTH-1:0] reg_rs_data_in,
    output logic                  pc_enable,
    output logic                  pc_reset,
    output logic                  halted
);
`ifdef DEBUG_CYCLE_COUNT_EN
    localparam int EXTRA = 32;
`else
    localparam int EXTRA = 0;
`endif
    localparam int SW = 5 * DATA_WIDTH + EXTRA;
    localparam int NBYTES = SW / 8;
    localparam int CW = $clog2(NBYTES);
    localparam logic [7:0] CMD_C = 8'h63, CMD_H = 8'h68, CMD_S = 8'h73, CMD_R = 8'h72, CMD_D = 8'h64;

    typedef enum logic [2:0] {IDLE, RUN, STEP, RST, SNAP, SEND, WAIT} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] snap_q, snap_d, obs;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    rst_cnt_q, rst_cnt_d, tx_data_q, tx_data_d;
    logic          tx_start_q, tx_start_d, pc_enable_q, pc_enable_d;
    logic          pc_reset_q, pc_reset_d, halted_q, halted_d, send;

`ifdef DEBUG_CYCLE_COUNT_EN
    logic [31:0] cyc_q, cyc_d;
    assign obs = {pc_addr_in, pc_instr_in, reg_w_data_in, reg_rt_data_in, reg_rs_data_in, cyc_q};
    always_comb begin
        cyc_d = (state_q == IDLE && uart.rx_valid && uart.rx_data == CMD_R) ? 32'd0 :
                pc_enable_q ? cyc_q + 32'd1 : cyc_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc_q <= '0;
        else cyc_q <= cyc_d;
    end
`else
    assign obs = {pc_addr_in, pc_instr_in, reg_w_data_in, reg_rt_data_in, reg_rs_data_in};
`endif

    always_comb begin
        state_d   = state_q;
        snap_d    = (state_q == SNAP) ? obs : snap_q;
        cnt_d     = cnt_q;
        rst_cnt_d = rst_cnt_q;
        case (state_q)
            IDLE: begin
                rst_cnt_d = 8'(RESET_CYCLES - 1);
                if (uart.rx_valid)
                    state_d = uart.rx_data == CMD_C ? RUN :
                              uart.rx_data == CMD_S ? STEP :
                              uart.rx_data == CMD_R ? RST :
                              uart.rx_data == CMD_D ? SNAP : IDLE;
            end
            RUN:  state_d = (uart.rx_valid && uart.rx_data == CMD_H) ? IDLE : RUN;
            STEP: state_d = SNAP;
            RST: begin
                rst_cnt_d = rst_cnt_q - 8'd1;
                state_d   = (rst_cnt_q == 8'd0) ? IDLE : RST;
            end
            SNAP: begin
                cnt_d   = '0;
                state_d = SEND;
            end
            SEND: state_d = SEND;
            WAIT: begin
                // the transmitter raises busy only after seeing tx_start, so skip that first cycle
                if (!tx_start_q && !uart.tx_busy) begin
                    state_d = (cnt_q == CW'(NBYTES - 1)) ? IDLE : SEND;
                    cnt_d   = (cnt_q == CW'(NBYTES - 1)) ? cnt_q : cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // a pending byte is launched in the same edge the transmitter is seen idle
        send        = (state_d == SEND) && !uart.tx_busy;
        state_d     = send ? WAIT : state_d;
        tx_start_d  = send;
        tx_data_d   = send ? snap_d[8 * (NBYTES - 1 - int'(cnt_d)) +: 8] : tx_data_q;
        pc_enable_d = (state_d == RUN) || (state_d == STEP);
        pc_reset_d  = (state_d == RST);
        halted_d    = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            cnt_q       <= '0;
            rst_cnt_q   <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            pc_enable_q <= 1'b0;
            pc_reset_q  <= 1'b0;
            halted_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            cnt_q       <= cnt_d;
            rst_cnt_q   <= rst_cnt_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            pc_enable_q <= pc_enable_d;
            pc_reset_q  <= pc_reset_d;
            halted_q    <= halted_d;
        end
    end

    assign uart.tx_data  = tx_data_q;
    assign uart.tx_start = tx_start_q;
    assign pc_enable     = pc_enable_q;
    assign pc_reset      = pc_reset_q;
    assign halted        = halted_q;
endmodule

// File: doc/debug_unit.md
# debug_unit

Host-side debug controller for the pipelined MIPS core. It sits between a UART byte receiver/transmitter pair and the pipeline top, and drives the pipeline's `pc_enable`/`pc_reset` inputs. It decodes single-byte host commands (run, halt, step, reset, dump) and streams the pipeline's debug observation words (PC, fetched instruction, write-back data, rs/rt read data) back to the host, byte by byte.

## Interface
- `DATA_WIDTH`, 32, width of each observed debug word; must be a multiple of 8.
- `RESET_CYCLES`, 2, number of cycles `pc_reset` is held high per reset command (1..255).
- `clk`  in  1  system clock, all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  command byte from UART receiver.
- `rx_valid`  in  1  one-cycle strobe qualifying `rx_data`.
- `tx_busy`  in  1  UART transmitter busy.
- `tx_data`  out  8  byte to transmit; stable from `tx_start` until next `tx_start`.
- `tx_start`  out  1  one-cycle strobe loading `tx_data` into transmitter.
- `pc_addr_in`, `pc_instr_in`, `reg_w_data_in`, `reg_rt_data_in`, `reg_rs_data_in`  in  DATA_WIDTH each  pipeline debug observation words.
- `pc_enable`  out  1  pipeline PC/advance enable.
- `pc_reset`  out  1  pipeline reset, active-high.
- `halted`  out  1  high when in IDLE (pipeline stopped, accepting commands).

## Operation
- States: IDLE, RUN, STEP, RST, SNAP, SEND, WAIT.
- Commands (accepted only on `rx_valid`): 0x63 'c' run, 0x68 'h' halt, 0x73 's' step, 0x72 'r' reset, 0x64 'd' dump.
- IDLE: 'c' -> RUN; 's' -> STEP; 'r' -> RST; 'd' -> SNAP; 'h' and unknown bytes ignored.
- RUN: `pc_enable`=1 every cycle; only 'h' accepted -> IDLE; all other bytes dropped.
- STEP: `pc_enable`=1 for exactly one cycle, then SNAP (auto-dump after every step).
- RST: `pc_reset`=1, `pc_enable`=0 for RESET_CYCLES cycles, then IDLE; no dump.
- SNAP: one cycle; latches all observation words into a snapshot register; then SEND.
- Dump order: pc_addr, pc_instr, reg_w_data, reg_rt_data, reg_rs_data; each word MSB byte first; DATA_WIDTH/8 bytes per word.
- SEND: when `tx_busy`=0, drive `tx_data` and pulse `tx_start`, go WAIT; if `tx_busy`=1, hold.
- WAIT: ignore `tx_busy` for the first cycle after `tx_start`, then wait for `tx_busy`=0; advance byte counter; last byte -> IDLE, else SEND.
- All bytes received in STEP/RST/SNAP/SEND/WAIT are dropped (no queuing).
- `pc_enable` and `pc_reset` never high simultaneously.

## Timing
- Reset (`reset_n`=0): state IDLE; `pc_enable`=0, `pc_reset`=0, `tx_start`=0, `tx_data`=0x00, `halted`=1; byte counter and snapshot cleared. Asserting `reset_n` mid-run or mid-dump aborts immediately; no partial byte strobes afterward.
- All outputs registered.
- 'c' strobed cycle N -> `pc_enable`=1 from N+1; 'h' strobed cycle M -> `pc_enable`=0 from M+1, `halted`=1 at M+1.
- 's' at N -> `pc_enable`=1 in cycle N+1 only; SNAP at N+2 (captures post-step values); first `tx_start` at N+3 if `tx_busy`=0.
- 'd' at N -> SNAP at N+1, first `tx_start` at N+2 if `tx_busy`=0.
- 'r' at N -> `pc_reset`=1 cycles N+1..N+RESET_CYCLES; `halted`=1 at N+RESET_CYCLES+1.
- Minimum byte spacing: 2 cycles plus transmitter busy time.

## Configuration
- `DEBUG_CYCLE_COUNT_EN`: when defined, a 32-bit counter increments on every cycle `pc_enable`=1, wraps at 0xFFFFFFFF to 0, and is cleared by `reset_n` and by the 'r' command. It is appended as a 6th dump word (4 bytes, MSB first), after reg_rs_data. When undefined, the counter is not implemented and a dump contains 5 words.

## Test plan
- Reset then 'd' with pc_addr_in=0x00000004, pc_instr_in=0x8C220000, other inputs 0, transmitter modeled busy 10 cycles/byte -> bytes 00 00 00 04 8C 22 00 00 then 12×00 (plus 4 counter bytes 00 if `DEBUG_CYCLE_COUNT_EN` is defined), then `halted`=1.
- 's' -> `pc_enable` high for exactly 1 cycle, then a dump carrying the values present at N+2; with `DEBUG_CYCLE_COUNT_EN`, three 's' commands yield a final counter word 00 00 00 03.
- 'c', wait 50 cycles, 'h' -> `pc_enable` high exactly 50 cycles (N+1..N+50); bytes 's'/'d' sent during RUN produce no `tx_start`.
- 'r' with RESET_CYCLES=2 -> `pc_reset` high exactly 2 cycles, `pc_enable` 0 throughout; counter reads 0 on the next dump.
- `tx_busy` held high for 100 cycles after 'd' -> no `tx_start` until `tx_busy` falls; then `tx_start` the next cycle. `reset_n` pulsed mid-dump -> all outputs return to reset values and no further `tx_start` occurs.
